sweep_gen: RTL and testbench

Parametrised successor to the single-channel DAC sweep: a sequencer that steps a WIDTH-bit DAC code from a start value by a signed-direction increment. Each point is held for a programmable dwell, and the whole pattern repeats a programmable number of loops. It adds up, down and triangle modes, saturation with a sticky clip flag, an explicit start/abort handshake and a done pulse. It sits between the register block and the DAC serialiser, clocked by the step clock.

---
 rtl/sweep_gen.sv | 191 +++++++++++++++++++
 tb/tb_sweep_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_gen.sv
// DAC code sweep sequencer: up/down/triangle ramps with per-point dwell,
// loop repetition, saturation with sticky clip, and a start/abort handshake.
module sweep_gen #(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned CNTW  = 12,
   parameter int unsigned LOOPW = 8
) (
   input  logic             i_stepCLK,
   input  logic             i_reset,
   input  logic             i_go,
   input  logic             i_abort,
   input  logic [1:0]       i_mode,
   input  logic [WIDTH-1:0] i_start,
   input  logic [WIDTH-1:0] i_step,
   input  logic [CNTW-1:0]  i_steps,
   input  logic [CNTW-1:0]  i_repeats,
   input  logic [LOOPW-1:0] i_loops,
   output logic [WIDTH-1:0] o_result,
   output logic             o_stepping,
   output logic             o_point,
   output logic             o_done,
   output logic             o_clip
);

   localparam int unsigned PRODW = WIDTH + CNTW;
   localparam int unsigned SUMW  = PRODW + 1;
   localparam logic [1:0] MODE_DOWN = 2'd1;
   localparam logic [1:0] MODE_TRI  = 2'd2;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [1:0]       modeR;
   logic [WIDTH-1:0] startR;
   logic [WIDTH-1:0] stepR;
   logic [CNTW-1:0]  stepsR;
   logic [CNTW-1:0]  dwellR;
   logic [LOOPW-1:0] loopsR;

   logic [CNTW-1:0]  dwellCnt;
   logic [CNTW-1:0]  kIdx;
   logic             desc;
   logic [LOOPW-1:0] loopCnt;

   logic [CNTW-1:0]  nextK;
   logic             nextDesc;
   logic             loopEnd;
   logic             lastLoop;
   logic             dwellExp;
   logic [WIDTH:0]   nextPt;

   // Returns {clip, code} for base +/- k*inc, saturated to the code range.
   function automatic logic [WIDTH:0] calcPoint(
      input logic [WIDTH-1:0] base,
      input logic [WIDTH-1:0] inc,
      input logic [CNTW-1:0]  k,
      input logic             down
   );
      logic [PRODW-1:0] prod;
      logic [SUMW-1:0]  sum;
      logic [WIDTH:0]   res;
      prod = PRODW'(inc) * PRODW'(k);
      sum  = '0;
      if (down) begin
         if (prod > PRODW'(base)) begin
            res = {1'b1, {WIDTH{1'b0}}};
         end else begin
            res = {1'b0, WIDTH'(PRODW'(base) - prod)};
         end
      end else begin
         sum = SUMW'(base) + SUMW'(prod);
         if (sum > SUMW'({WIDTH{1'b1}})) begin
            res = {1'b1, {WIDTH{1'b1}}};
         end else begin
            res = {1'b0, sum[WIDTH-1:0]};
         end
      end
      return res;
   endfunction

   // Next point index / triangle phase and end-of-loop detection.
   always_comb begin
      nextK    = kIdx;
      nextDesc = desc;
      loopEnd  = 1'b0;
      if (modeR == MODE_TRI) begin
         if (!desc) begin
            if (kIdx == stepsR) begin
               if (stepsR == '0) begin
                  loopEnd = 1'b1;
               end else begin
                  nextDesc = 1'b1;
                  nextK    = kIdx - CNTW'(1);
               end
            end else begin
               nextK = kIdx + CNTW'(1);
            end
         end else if (kIdx == '0) begin
            loopEnd = 1'b1;
         end else begin
            nextK = kIdx - CNTW'(1);
         end
      end else begin
         if (kIdx == stepsR) begin
            loopEnd = 1'b1;
         end else begin
            nextK = kIdx + CNTW'(1);
         end
      end
      if (loopEnd) begin
         nextK    = '0;
         nextDesc = 1'b0;
      end
      nextPt   = calcPoint(startR, stepR, nextK, modeR == MODE_DOWN);
      dwellExp = (dwellCnt == dwellR - CNTW'(1));
      lastLoop = (loopsR != '0) && (loopCnt == loopsR - LOOPW'(1));
   end

   // Sequencer state machine with registered outputs.
   always_ff @(posedge i_stepCLK or negedge i_reset) begin
      if (!i_reset) begin
         state      <= IDLE;
         modeR      <= '0;
         startR     <= '0;
         stepR      <= '0;
         stepsR     <= '0;
         dwellR     <= '0;
         loopsR     <= '0;
         dwellCnt   <= '0;
         kIdx       <= '0;
         desc       <= 1'b0;
         loopCnt    <= '0;
         o_result   <= '0;
         o_stepping <= 1'b0;
         o_point    <= 1'b0;
         o_done     <= 1'b0;
         o_clip     <= 1'b0;
      end else begin
         o_point <= 1'b0;
         o_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (i_go && !i_abort) begin
                  state      <= RUN;
                  modeR      <= i_mode;
                  startR     <= i_start;
                  stepR      <= i_step;
                  stepsR     <= i_steps;
                  dwellR     <= (i_repeats == '0) ? CNTW'(1) : i_repeats;
                  loopsR     <= i_loops;
                  dwellCnt   <= '0;
                  kIdx       <= '0;
                  desc       <= 1'b0;
                  loopCnt    <= '0;
                  // The first point is the start code itself, always in range.
                  o_result   <= i_start;
                  o_stepping <= 1'b1;
                  o_point    <= 1'b1;
                  o_clip     <= 1'b0;
               end
            end
            RUN: begin
               if (i_abort) begin
                  state      <= IDLE;
                  o_stepping <= 1'b0;
               end else if (dwellExp) begin
                  dwellCnt <= '0;
                  if (loopEnd && lastLoop) begin
                     state      <= IDLE;
                     o_stepping <= 1'b0;
                     o_done     <= 1'b1;
                  end else begin
                     kIdx     <= nextK;
                     desc     <= nextDesc;
                     if (loopEnd && loopsR != '0) begin
                        loopCnt <= loopCnt + LOOPW'(1);
                     end
                     o_result <= nextPt[WIDTH-1:0];
                     o_clip   <= o_clip | nextPt[WIDTH];
                     o_point  <= 1'b1;
                  end
               end else begin
                  dwellCnt <= dwellCnt + CNTW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sweep_gen.sv
// Directed self-checking bench for sweep_gen with hand-computed code sequences.
module tb_sweep_gen;

   logic        stepClk = 1'b0;
   logic        rstN;
   logic        go;
   logic        abort;
   logic [1:0]  mode;
   logic [11:0] start;
   logic [11:0] step;
   logic [11:0] steps;
   logic [11:0] repeats;
   logic [7:0]  loops;
   logic [11:0] result;
   logic        stepping;
   logic        point;
   logic        done;
   logic        clip;

   int vecs = 0;
   int errs = 0;

   sweep_gen #(.WIDTH(12), .CNTW(12), .LOOPW(8)) dut (
      .i_stepCLK (stepClk),
      .i_reset   (rstN),
      .i_go      (go),
      .i_abort   (abort),
      .i_mode    (mode),
      .i_start   (start),
      .i_step    (step),
      .i_steps   (steps),
      .i_repeats (repeats),
      .i_loops   (loops),
      .o_result  (result),
      .o_stepping(stepping),
      .o_point   (point),
      .o_done    (done),
      .o_clip    (clip)
   );

   always #5 stepClk = ~stepClk;

   task automatic tick();
      @(posedge stepClk);
      #1;
   endtask

   task automatic setup(input logic [1:0] m, input int s, input int st, input int n,
                        input int r, input int l);
      mode = m; start = 12'(s); step = 12'(st); steps = 12'(n);
      repeats = 12'(r); loops = 8'(l);
   endtask

   task automatic test_reset();
      rstN = 1'b0; go = 1'b0; abort = 1'b0;
      setup(2'd0, 0, 0, 0, 0, 0);
      tick(); tick();
      vecs++; if (result !== 12'd0) begin errs++; $display("FAIL reset_result got %0d want 0", result); end
      vecs++; if ({stepping, point, done, clip} !== 4'b0) begin errs++;
         $display("FAIL reset_flags got %b want 0000", {stepping, point, done, clip}); end
      rstN = 1'b1;
      tick();
      // Start a sweep and reset it at a non-zero code.
      setup(2'd0, 100, 1, 10, 1, 1);
      go = 1'b1; tick(); go = 1'b0;
      tick(); tick();
      vecs++; if (result !== 12'd102) begin errs++; $display("FAIL pre_reset_code got %0d want 102", result); end
      #2 rstN = 1'b0;
      #1;
      vecs++; if (result !== 12'd0 || stepping !== 1'b0 || point !== 1'b0) begin errs++;
         $display("FAIL async_reset got code=%0d stepping=%b point=%b want 0 0 0", result, stepping, point); end
      tick();
      rstN = 1'b1;
      tick();
      vecs++; if (stepping !== 1'b0) begin errs++; $display("FAIL post_reset_idle got %b want 0", stepping); end
      go = 1'b1; tick(); go = 1'b0;
      vecs++; if (result !== 12'd100 || stepping !== 1'b1 || point !== 1'b1) begin errs++;
         $display("FAIL restart got code=%0d stepping=%b point=%b want 100 1 1", result, stepping, point); end
      tick();
      vecs++; if (result !== 12'd101 || point !== 1'b1) begin errs++;
         $display("FAIL restart_second got code=%0d point=%b want 101 1", result, point); end
      abort = 1'b1; tick(); abort = 1'b0;
      tick();
   endtask

   task automatic test_up_full();
      setup(2'd0, 0, 1, 4095, 0, 1);
      go = 1'b1; tick(); go = 1'b0;
      for (int k = 0; k < 4096; k++) begin
         vecs++; if (result !== 12'(k) || point !== 1'b1 || stepping !== 1'b1 || clip !== 1'b0 || done !== 1'b0) begin
            errs++; $display("FAIL up_full k=%0d got code=%0d pt=%b stp=%b clip=%b done=%b want %0d 1 1 0 0",
                             k, result, point, stepping, clip, done, k); end
         tick();
      end
      vecs++; if (done !== 1'b1 || stepping !== 1'b0 || result !== 12'd4095 || point !== 1'b0) begin errs++;
         $display("FAIL up_full_done got done=%b stp=%b code=%0d pt=%b want 1 0 4095 0", done, stepping, result, point); end
      tick();
      vecs++; if (done !== 1'b0) begin errs++; $display("FAIL up_full_done_pulse got %b want 0", done); end
   endtask

   task automatic test_triangle();
      int expv[10];
      expv = '{10, 15, 20, 15, 10, 10, 15, 20, 15, 10};
      setup(2'd2, 10, 5, 2, 3, 2);
      go = 1'b1; tick(); go = 1'b0;
      for (int p = 0; p < 10; p++) begin
         for (int c = 0; c < 3; c++) begin
            vecs++; if (result !== 12'(expv[p]) || point !== (c == 0) || stepping !== 1'b1 || done !== 1'b0) begin
               errs++; $display("FAIL triangle p=%0d c=%0d got code=%0d pt=%b stp=%b done=%b want %0d %b 1 0",
                                p, c, result, point, stepping, done, expv[p], (c == 0)); end
            tick();
         end
      end
      vecs++; if (done !== 1'b1 || stepping !== 1'b0 || result !== 12'd10) begin errs++;
         $display("FAIL triangle_done got done=%b stp=%b code=%0d want 1 0 10", done, stepping, result); end
      tick();
   endtask

   task automatic test_clip();
      int expv[4];
      int expc[4];
      expv = '{4090, 4094, 4095, 4095};
      expc = '{0, 0, 1, 1};
      setup(2'd0, 4090, 4, 3, 1, 1);
      go = 1'b1; tick(); go = 1'b0;
      for (int p = 0; p < 4; p++) begin
         vecs++; if (result !== 12'(expv[p]) || clip !== 1'(expc[p])) begin errs++;
            $display("FAIL clip_seq p=%0d got code=%0d clip=%b want %0d %0d", p, result, clip, expv[p], expc[p]); end
         tick();
      end
      vecs++; if (done !== 1'b1 || clip !== 1'b1) begin errs++;
         $display("FAIL clip_done got done=%b clip=%b want 1 1", done, clip); end
      tick(); tick();
      vecs++; if (clip !== 1'b1 || result !== 12'd4095) begin errs++;
         $display("FAIL clip_sticky got clip=%b code=%0d want 1 4095", clip, result); end
   endtask

   task automatic test_abort();
      int expv[4];
      expv = '{3, 1, 0, 0};
      setup(2'd1, 3, 2, 3, 2, 0);
      go = 1'b1; tick(); go = 1'b0;
      vecs++; if (clip !== 1'b0) begin errs++; $display("FAIL clip_clear_on_go got %b want 0", clip); end
      for (int l = 0; l < 2; l++) begin
         for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 2; c++) begin
               vecs++; if (result !== 12'(expv[p]) || point !== (c == 0) || clip !== (l > 0 || p >= 2)
                           || stepping !== 1'b1) begin
                  errs++; $display("FAIL down_loop l=%0d p=%0d c=%0d got code=%0d pt=%b clip=%b stp=%b want %0d",
                                   l, p, c, result, point, clip, stepping, expv[p]); end
               tick();
            end
         end
      end
      vecs++; if (result !== 12'd3 || point !== 1'b1) begin errs++;
         $display("FAIL down_wrap got code=%0d pt=%b want 3 1", result, point); end
      tick(); tick();
      vecs++; if (result !== 12'd1 || point !== 1'b1) begin errs++;
         $display("FAIL down_third_loop got code=%0d pt=%b want 1 1", result, point); end
      abort = 1'b1; tick(); abort = 1'b0;
      vecs++; if (stepping !== 1'b0 || result !== 12'd1 || point !== 1'b0 || done !== 1'b0) begin errs++;
         $display("FAIL abort got stp=%b code=%0d pt=%b done=%b want 0 1 0 0", stepping, result, point, done); end
      tick(); tick();
      vecs++; if (done !== 1'b0 || result !== 12'd1 || stepping !== 1'b0) begin errs++;
         $display("FAIL abort_hold got done=%b code=%0d stp=%b want 0 1 0", done, result, stepping); end
   endtask

   task automatic test_shadow_and_ignore();
      int expv[3];
      expv = '{50, 53, 56};
      setup(2'd0, 50, 3, 2, 2, 1);
      go = 1'b1; tick();
      setup(2'd1, 999, 7, 9, 1, 5);
      for (int p = 0; p < 3; p++) begin
         for (int c = 0; c < 2; c++) begin
            vecs++; if (result !== 12'(expv[p]) || point !== (c == 0) || stepping !== 1'b1) begin errs++;
               $display("FAIL shadow p=%0d c=%0d got code=%0d pt=%b stp=%b want %0d %b 1",
                        p, c, result, point, stepping, expv[p], (c == 0)); end
            if (p == 1 && c == 1) go = 1'b0;
            tick();
         end
      end
      vecs++; if (done !== 1'b1 || stepping !== 1'b0 || result !== 12'd56) begin errs++;
         $display("FAIL shadow_done got done=%b stp=%b code=%0d want 1 0 56", done, stepping, result); end
      tick();
   endtask

   task automatic test_go_abort_idle();
      setup(2'd0, 200, 1, 5, 0, 1);
      go = 1'b1; abort = 1'b1;
      tick(); tick();
      vecs++; if (stepping !== 1'b0 || point !== 1'b0 || result !== 12'd56) begin errs++;
         $display("FAIL go_abort_idle got stp=%b pt=%b code=%0d want 0 0 56", stepping, point, result); end
      go = 1'b0; abort = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      setup(2'd2, 77, 9, 0, 5, 3);
      go = 1'b1; tick(); go = 1'b0;
      for (int c = 0; c < 15; c++) begin
         vecs++; if (result !== 12'd77 || point !== (c % 5 == 0) || stepping !== 1'b1 || done !== 1'b0) begin
            errs++; $display("FAIL steps_zero c=%0d got code=%0d pt=%b stp=%b done=%b want 77 %b 1 0",
                             c, result, point, stepping, done, (c % 5 == 0)); end
         tick();
      end
      vecs++; if (done !== 1'b1 || stepping !== 1'b0 || result !== 12'd77) begin errs++;
         $display("FAIL steps_zero_done got done=%b stp=%b code=%0d want 1 0 77", done, stepping, result); end
      // Restart on the done cycle.
      setup(2'd0, 5, 1, 0, 0, 1);
      go = 1'b1; tick(); go = 1'b0;
      vecs++; if (result !== 12'd5 || stepping !== 1'b1 || point !== 1'b1 || done !== 1'b0) begin errs++;
         $display("FAIL rego_on_done got code=%0d stp=%b pt=%b done=%b want 5 1 1 0", result, stepping, point, done); end
      tick();
      vecs++; if (done !== 1'b1 || stepping !== 1'b0) begin errs++;
         $display("FAIL rego_done got done=%b stp=%b want 1 0", done, stepping); end
      tick();
   endtask

   initial begin
      test_reset();
      test_up_full();
      test_triangle();
      test_clip();
      test_abort();
      test_shadow_and_ignore();
      test_go_abort_idle();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
